// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt controller.
// Nesting is enabled by defining IRQ_NEST_EN when compiling irq_ctrl.
package irq_pkg;

    localparam int N_IRQ_DEF = 2;
    localparam int IRQ_ID_W  = $clog2(N_IRQ_DEF);

    localparam logic [4:0] EXC_INT = 5'd0;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } irq_state_e;

    function automatic logic [4:0] prio_enc(input logic [31:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = 5'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-line synchroniser with a registered rising-edge pulse.
// The pulse lands one cycle after the last sync stage sees the line high.
import irq_pkg::*;

module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic edge_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    assign edge_pulse = edge_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge capture, mask/priority, request FSM.
// Define IRQ_NEST_EN to allow higher-priority requests during service.
import irq_pkg::*;

module irq_ctrl #(
    parameter int N_IRQ       = N_IRQ_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                    clk_gl,
    input  logic                                    rst,
    input  logic [N_IRQ-1:0]                        interrupt,
    input  logic [N_IRQ-1:0]                        irq_mask,
    input  logic                                    glb_ie,
    input  logic                                    irq_ack,
    input  logic                                    eret,
    output logic                                    irq_req,
    output logic [((N_IRQ>1)?$clog2(N_IRQ):1)-1:0]  irq_id,
    output logic [N_IRQ-1:0]                        pending,
    output logic [N_IRQ-1:0]                        in_service
);

    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [N_IRQ-1:0] ONE = N_IRQ'(1);

    irq_state_e        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  svc_q, svc_d;
    logic [N_IRQ-1:0]  edges, cand, svc_low;
    logic [N_IRQ-1:0]  ack_clr, svc_set, svc_clr;
    logic [ID_W-1:0]   win;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i      (clk_gl),
            .rst_ni     (rst),
            .line_i     (interrupt[g]),
            .edge_pulse (edges[g])
        );
    end

    assign cand    = pending_q & irq_mask;
    assign win     = ID_W'(prio_enc(32'(cand)));
    // Isolates the lowest set index, i.e. the highest-priority active level.
    assign svc_low = svc_q & (~svc_q + ONE);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        ack_clr = '0;
        svc_set = '0;
        svc_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (glb_ie && cand != '0) begin
                    id_d    = win;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    ack_clr[id_q] = 1'b1;
                    svc_set[id_q] = 1'b1;
                    state_d       = SERVICE;
                end else if (!glb_ie || !irq_mask[id_q]) begin
                    state_d = (svc_q != '0) ? SERVICE : IDLE;
                end
            end
            SERVICE: begin
                if (eret) begin
                    svc_clr = svc_low;
                    if ((svc_q & ~svc_low) == '0) state_d = IDLE;
                end
`ifdef IRQ_NEST_EN
                else if (glb_ie && (cand & (svc_low - ONE)) != '0) begin
                    id_d    = win;
                    state_d = REQ;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        // A new edge on the line being acked keeps it pending.
        pending_d = (pending_q & ~ack_clr) | edges;
        svc_d     = (svc_q & ~svc_clr) | svc_set;
    end

    always_ff @(posedge clk_gl) begin
        if (!rst) begin
            state_q   <= IDLE;
            id_q      <= '0;
            pending_q <= '0;
            svc_q     <= '0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            svc_q     <= svc_d;
        end
    end

    assign irq_req    = (state_q == REQ);
    assign irq_id     = id_q;
    assign pending    = pending_q;
    assign in_service = svc_q;

endmodule
